// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared constants and types for the two-port line-memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 256;

    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_D  = 1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Requester, memory and status signals of the line-memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0_enable_i;
    logic              req0_write_i;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_ack_o;
    logic [DATA_W-1:0] req0_data_o;

    logic              req1_enable_i;
    logic              req1_write_i;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_ack_o;
    logic [DATA_W-1:0] req1_data_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    logic [1:0]        grant_o;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
        output req0_ack_o, req0_data_o,
        input  req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
        output req1_ack_o, req1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i,
        output grant_o, busy_o, timeout_o
    );

    modport master (
        output req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
        input  req0_ack_o, req0_data_o,
        output req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
        input  req1_ack_o, req1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i,
        input  grant_o, busy_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick2
// Brief   : Combinational two-way pick producing a one-hot grant.
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    input  logic       i_fixed_prio,
    output logic [1:0] o_grant
);
    always_comb begin
        o_grant = 2'b00;
        if (i_req == 2'b11) begin
            // On a tie the port that did not go last wins, unless port 1 is pinned
            if (i_fixed_prio || !i_last_served) begin
                o_grant = 2'b10;
            end else begin
                o_grant = 2'b01;
            end
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end else if (i_req[0]) begin
            o_grant = 2'b01;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Serialises whole-line reads/writes from ifetch and dcache onto
//           one registered off-chip memory port.
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);
    localparam logic c_FIXED = (FIXED_PRIO != 0);

    state_t            r_state;
    logic              r_last_served;
    logic [1:0]        r_grant;
    logic              r_busy;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic              w_timeout;

    assign w_req = {bus.req1_enable_i, bus.req0_enable_i};

    rr_pick2 u_pick (
        .i_req         (w_req),
        .i_last_served (r_last_served),
        .i_fixed_prio  (c_FIXED),
        .o_grant       (w_pick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
            r_grant       <= 2'b00;
            r_busy        <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_data0       <= '0;
            r_data1       <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_grant  <= w_pick;
                        r_busy   <= 1'b1;
                        r_mem_en <= 1'b1;
                        r_state  <= BUSY;
                        if (w_pick[PORT_D]) begin
                            r_mem_wr   <= bus.req1_write_i;
                            r_mem_addr <= bus.req1_addr_i;
                            r_mem_data <= bus.req1_data_i;
                        end else begin
                            r_mem_wr   <= bus.req0_write_i;
                            r_mem_addr <= bus.req0_addr_i;
                            r_mem_data <= bus.req0_data_i;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ack_i) begin
                        r_mem_en      <= 1'b0;
                        r_mem_wr      <= 1'b0;
                        r_last_served <= r_grant[PORT_D];
                        r_state       <= RESP;
                        if (r_grant[PORT_D]) begin
                            r_ack1 <= 1'b1;
                            if (!r_mem_wr) r_data1 <= bus.mem_data_i;
                        end else begin
                            r_ack0 <= 1'b1;
                            if (!r_mem_wr) r_data0 <= bus.mem_data_i;
                        end
                    end
                end
                RESP: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wd_on
            localparam int              c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);
            localparam logic [c_WD_W-1:0] c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 1);

            logic [c_WD_W-1:0] r_wd_cnt;
            logic              r_timeout;

            // Counter rests at zero while idle, so it is already clear at grant
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    r_wd_cnt  <= '0;
                    r_timeout <= 1'b0;
                end else if (r_state == IDLE) begin
                    r_wd_cnt <= '0;
                end else if (r_state == BUSY && r_wd_cnt != c_WD_LIMIT) begin
                    r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    if (r_wd_cnt == c_WD_LAST) r_timeout <= 1'b1;
                end
            end

            assign w_timeout = r_timeout;
        end else begin : g_wd_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign bus.mem_enable_o = r_mem_en;
    assign bus.mem_write_o  = r_mem_wr;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.req0_ack_o   = r_ack0;
    assign bus.req1_ack_o   = r_ack1;
    assign bus.req0_data_o  = r_data0;
    assign bus.req1_data_o  = r_data1;
    assign bus.grant_o      = r_grant;
    assign bus.busy_o       = r_busy;
    assign bus.timeout_o    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench: round-robin/watchdog instance plus a
//           fixed-priority instance, against a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ba ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bb ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(64)) u_dut_rr (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ba.slave)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0)) u_dut_fp (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bb.slave)
    );

    // Reference state: memory contents, last port served, per-port read lines
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            ls_a;
    logic [DW-1:0] exp_data [2];
    int            served_q [$];

    localparam logic [DW-1:0] c_LINE_89 = {8{32'h8888_9999}};
    localparam logic [DW-1:0] c_LINE_EC = {4{64'hECFA_1234_5678_9ABC}};

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (!mem_model.exists(a)) mem_model[a] = rand256();
        return mem_model[a];
    endfunction

    task automatic set_req_a(input int p, input bit en, input bit wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            ba.req0_enable_i = en; ba.req0_write_i = wr; ba.req0_addr_i = a; ba.req0_data_i = d;
        end else begin
            ba.req1_enable_i = en; ba.req1_write_i = wr; ba.req1_addr_i = a; ba.req1_data_i = d;
        end
    endtask

    task automatic check_zero_a(input string tag);
        check_val({tag, "_mem_en"},  ba.mem_enable_o, 0);
        check_val({tag, "_mem_wr"},  ba.mem_write_o, 0);
        check_val({tag, "_mem_addr"}, ba.mem_addr_o, 0);
        check_val({tag, "_mem_data"}, ba.mem_data_o, 0);
        check_val({tag, "_acks"},    {ba.req1_ack_o, ba.req0_ack_o}, 0);
        check_val({tag, "_data0"},   ba.req0_data_o, 0);
        check_val({tag, "_data1"},   ba.req1_data_o, 0);
        check_val({tag, "_grant"},   ba.grant_o, 0);
        check_val({tag, "_busy"},    ba.busy_o, 0);
        check_val({tag, "_timeout"}, ba.timeout_o, 0);
    endtask

    // Serve every requested port to completion; winner order from the arbitration rules
    task automatic round_a(input bit [1:0] en, input bit [1:0] wr,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int dly);
        bit [1:0]      pend;
        int            win;
        int            waited;
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        pend = en;
        set_req_a(0, en[0], wr[0], a0, d0);
        set_req_a(1, en[1], wr[1], a1, d1);
        while (pend != 2'b00) begin
            if (pend == 2'b11) win = (ls_a == 1) ? 0 : 1;
            else               win = pend[1] ? 1 : 0;
            addr  = (win == 1) ? a1 : a0;
            wdata = (win == 1) ? d1 : d0;
            is_wr = wr[win];
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!ba.mem_enable_o && waited < 8);
            check_val("grant_latency", waited, 1);
            served_q.push_back(int'(ba.grant_o[1]));
            check_val("grant", ba.grant_o, (win == 1) ? 2'b10 : 2'b01);
            check_val("busy", ba.busy_o, 1);
            check_val("mem_write", ba.mem_write_o, is_wr);
            check_val("mem_addr", ba.mem_addr_o, addr);
            if (is_wr) check_val("mem_wdata", ba.mem_data_o, wdata);
            // Requester inputs are ignored while busy: scramble the winner's
            set_req_a(win, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), rand256());
            for (int i = 0; i < dly; i++) begin
                ba.mem_data_i = rand256();
                tick();
                check_val("hold_en", ba.mem_enable_o, 1);
                check_val("hold_addr", ba.mem_addr_o, addr);
                check_val("hold_wr", ba.mem_write_o, is_wr);
                if (is_wr) check_val("hold_wdata", ba.mem_data_o, wdata);
                check_val("early_ack", {ba.req1_ack_o, ba.req0_ack_o}, 0);
            end
            rdata = is_wr ? rand256() : mem_read(addr);
            if (is_wr) mem_model[addr] = wdata;
            else       exp_data[win] = rdata;
            ba.mem_data_i = rdata;
            ba.mem_ack_i  = 1'b1;
            tick();
            ba.mem_ack_i  = 1'($urandom_range(0, 1));
            ba.mem_data_i = rand256();
            if (win == 1) ba.req1_enable_i = 1'b0;
            else          ba.req0_enable_i = 1'b0;
            pend[win] = 1'b0;
            ls_a = win;
            check_val("ack", {ba.req1_ack_o, ba.req0_ack_o}, (win == 1) ? 2'b10 : 2'b01);
            check_val("mem_en_drop", ba.mem_enable_o, 0);
            check_val("mem_wr_drop", ba.mem_write_o, 0);
            check_val("resp_busy", ba.busy_o, 1);
            check_val("resp_grant", ba.grant_o, (win == 1) ? 2'b10 : 2'b01);
            check_val("rdata0", ba.req0_data_o, exp_data[0]);
            check_val("rdata1", ba.req1_data_o, exp_data[1]);
            tick();
            ba.mem_ack_i = 1'b0;
            check_val("ack_pulse", {ba.req1_ack_o, ba.req0_ack_o}, 0);
            check_val("idle_grant", ba.grant_o, 0);
            check_val("idle_busy", ba.busy_o, 0);
        end
    endtask

    task automatic serve_b(input int exp_win, input bit drop1, input int dly);
        int waited;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!bb.mem_enable_o && waited < 8);
        check_val("fp_grant_seen", waited < 8, 1);
        check_val("fp_grant", bb.grant_o, (exp_win == 1) ? 2'b10 : 2'b01);
        repeat (dly) tick();
        check_val("fp_no_timeout", bb.timeout_o, 0);
        bb.mem_data_i = rand256();
        bb.mem_ack_i  = 1'b1;
        tick();
        bb.mem_ack_i  = 1'b0;
        check_val("fp_ack", {bb.req1_ack_o, bb.req0_ack_o}, (exp_win == 1) ? 2'b10 : 2'b01);
        if (drop1)        bb.req1_enable_i = 1'b0;
        if (exp_win == 0) bb.req0_enable_i = 1'b0;
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit [1:0]      en;
        bit [1:0]      wr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;

        set_req_a(0, 0, 0, '0, '0);
        set_req_a(1, 0, 0, '0, '0);
        ba.mem_ack_i = 1'b0; ba.mem_data_i = '0;
        bb.req0_enable_i = 1'b0; bb.req0_write_i = 1'b0; bb.req0_addr_i = '0; bb.req0_data_i = '0;
        bb.req1_enable_i = 1'b0; bb.req1_write_i = 1'b0; bb.req1_addr_i = '0; bb.req1_data_i = '0;
        bb.mem_ack_i = 1'b0; bb.mem_data_i = '0;
        ls_a = 1;
        exp_data[0] = '0;
        exp_data[1] = '0;

        rst_n = 1'b0;
        tick();
        tick();
        check_zero_a("reset");
        check_val("fp_reset_grant", bb.grant_o, 0);
        rst_n = 1'b1;
        tick();

        // Stray memory acks while idle must not produce requester acks
        ba.mem_ack_i = 1'b1;
        tick();
        tick();
        ba.mem_ack_i = 1'b0;
        check_val("stray_ack", {ba.req1_ack_o, ba.req0_ack_o}, 0);
        check_val("stray_grant", ba.grant_o, 0);

        // Single port-1 read with a 10-cycle memory latency
        mem_model[32'h20] = c_LINE_89;
        round_a(2'b10, 2'b00, '0, 32'h20, '0, '0, 10);
        check_val("t1_data1", ba.req1_data_o, c_LINE_89);
        check_val("t1_data0", ba.req0_data_o, 0);

        // Simultaneous requests alternate under round-robin
        round_a(2'b11, 2'b00, 32'h60, 32'h80, '0, '0, 3);
        round_a(2'b11, 2'b00, 32'h60, 32'h80, '0, '0, 0);
        check_val("order_n", served_q.size(), 5);
        if (served_q.size() == 5) begin
            check_val("order1", served_q[1], 0);
            check_val("order2", served_q[2], 1);
            check_val("order3", served_q[3], 0);
            check_val("order4", served_q[4], 1);
        end

        // Write then read back
        round_a(2'b01, 2'b01, 32'h40, '0, c_LINE_EC, '0, 5);
        round_a(2'b01, 2'b00, 32'h40, '0, '0, '0, 2);
        check_val("ecfa_readback", ba.req0_data_o, c_LINE_EC);

        for (int t = 0; t < 40; t++) begin
            en  = 2'($urandom_range(1, 3));
            wr  = 2'($urandom_range(0, 3));
            ra0 = AW'($urandom_range(0, 7)) << 5;
            ra1 = AW'($urandom_range(0, 7)) << 5;
            round_a(en, wr, ra0, ra1, rand256(), rand256(), $urandom_range(0, 12));
        end

        // Memory never answers: watchdog fires 64 cycles after grant
        set_req_a(0, 1, 0, 32'h100, '0);
        tick();
        check_val("wd_grant", ba.grant_o, 2'b01);
        ba.req0_enable_i = 1'b0;
        repeat (63) tick();
        check_val("wd_before", ba.timeout_o, 0);
        tick();
        check_val("wd_fire", ba.timeout_o, 1);
        check_val("wd_mem_en", ba.mem_enable_o, 1);
        repeat (5) tick();
        check_val("wd_sticky", ba.timeout_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ls_a = 1;
        exp_data[0] = '0;
        exp_data[1] = '0;
        check_zero_a("wd_reset");

        // Reset three cycles into a port-1 read abandons it
        set_req_a(1, 1, 0, 32'h200, rand256());
        tick();
        check_val("abort_grant", ba.grant_o, 2'b10);
        tick();
        tick();
        rst_n = 1'b0;
        ba.req1_enable_i = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero_a("abort_reset");
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("abort_no_ack", {ba.req1_ack_o, ba.req0_ack_o}, 0);
        end
        round_a(2'b01, 2'b00, 32'h20, '0, '0, '0, 4);

        // Fixed priority: port 1 wins every tie until it stops asking
        bb.req0_addr_i = 32'h300;
        bb.req1_addr_i = 32'h400;
        bb.req0_enable_i = 1'b1;
        bb.req1_enable_i = 1'b1;
        serve_b(1, 0, 2);
        serve_b(1, 0, 3);
        serve_b(1, 1, 1);
        serve_b(0, 0, 2);
        bb.req0_enable_i = 1'b1;
        serve_b(0, 0, 70);
        check_val("fp_idle_grant", bb.grant_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 256-bit off-chip data memory interface (enable/write/addr/data with ack) between the instruction-fetch refill path (port 0) and the data cache (port 1).
- Sits between the CPU's cache controllers and Data_Memory.
- Serialises whole-line transactions and registers all memory-side signals.
- Returns each completion to the owning requester as a one-cycle ack.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 256, cache line width.
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 1 (dcache) always wins ties.
- TIMEOUT_CYCLES, 64: cycles in BUSY without mem_ack_i before timeout_o sets; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- req0_enable_i  in  1  port 0 request; held high until req0_ack_o is seen.
- req0_write_i  in  1  port 0: 1 = line write, 0 = line read.
- req0_addr_i  in  ADDR_W  port 0 line address.
- req0_data_i  in  DATA_W  port 0 write line.
- req0_ack_o  out  1  port 0 completion pulse.
- req0_data_o  out  DATA_W  port 0 read line.
- req1_* (enable_i, write_i, addr_i, data_i, ack_o, data_o): same set for port 1.
- mem_enable_o  out  1  to memory: request.
- mem_write_o  out  1  to memory: write.
- mem_addr_o  out  ADDR_W  to memory: address.
- mem_data_o  out  DATA_W  to memory: write line.
- mem_ack_i  in  1  memory completion pulse.
- mem_data_i  in  DATA_W  memory read line, valid with mem_ack_i.
- grant_o  out  2  one-hot current owner; 00 when idle.
- busy_o  out  1  transaction in flight.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_i low at an edge):
  - State goes to IDLE.
  - All outputs zero: mem_*, reqN_ack_o, reqN_data_o, grant_o, busy_o, timeout_o.
  - Round-robin pointer set to last_served = 1, so port 0 is preferred first.
  - Reset mid-transaction abandons it silently with no ack to either port. Data_Memory is reset concurrently.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Samples req0_enable_i and req1_enable_i.
  - None high: stay in IDLE.
  - Exactly one high: grant that port.
  - Both high, FIXED_PRIO=0: grant the port that is not last_served.
  - Both high, FIXED_PRIO=1: grant port 1.
  - On grant: capture the winner's write/addr/data into mem_* registers, set mem_enable_o=1, busy_o=1, grant_o one-hot, clear the watchdog counter, and go to BUSY.
- BUSY:
  - mem_* outputs are held stable; requester inputs are ignored.
  - Watchdog counter increments every cycle. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), timeout_o sets and stays set until reset. The transaction keeps waiting.
  - When mem_ack_i=1:
    - Drop mem_enable_o and mem_write_o.
    - Assert the owner's reqN_ack_o for exactly one cycle.
    - On a read, load mem_data_i into the owner's reqN_data_o. On a write, reqN_data_o is unchanged.
    - Update last_served to the owner and go to RESP.
- RESP:
  - Lasts one cycle. mem_enable_o=0 and the requester enable is ignored during it, so the requester can drop enable.
  - Then goes to IDLE. grant_o and busy_o clear on entry to IDLE.
- reqN_data_o holds its value until the next read completion for that port.
- mem_ack_i seen in IDLE or RESP is ignored.
- Latency: request sampled at edge k → mem_enable_o high from cycle k+1. mem_ack_i at edge m → reqN_ack_o high during cycle m+1. Next grant can happen at edge m+2 at the earliest.
- A requester that drops enable while in BUSY does not cancel the transaction; it still receives the ack.
- No combinational path from any input to any output.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - Port id constants PORT_IF=0, PORT_D=1.
  - Default ADDR_W and DATA_W.
- Sub-module rr_pick2: combinational 2-way pick from (req[1:0], last_served, fixed_prio) to a one-hot grant. Instantiated once.

Test Plan:
- Single read, port 1, addr 0x0000_0020; memory returns line 0x8888_9999… after 10 cycles → req1_ack_o pulses one cycle with req1_data_o equal to that line; req0_ack_o stays 0; grant_o=10 during BUSY.
- Both ports request in the same cycle out of reset, FIXED_PRIO=0 → port 0 served first, then port 1 granted at ack+2. Repeat both requests → order alternates 0,1,0,1.
- FIXED_PRIO=1, both ports request continuously for 3 transactions → port 1 served all 3 times and port 0 starves. Port 1 then drops its request → port 0 is granted next.
- Port 0 write of 256'hECFA… to 0x0000_0040 → mem_write_o=1 with that data, held stable until ack. req0_ack_o pulses; req0_data_o unchanged; a subsequent read of 0x40 returns ECFA….
- Memory never acks, TIMEOUT_CYCLES=64 → timeout_o rises exactly 64 cycles after grant and stays high, mem_enable_o stays 1. Then assert rst_i=0 for one edge → all outputs 0 and state IDLE.
- Reset asserted 3 cycles into a port 1 read → no req1_ack_o ever issued. After reset release, a new port 0 request is granted normally.
